// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle base ops plus iterative RV M-extension
// multiply/divide behind a start/busy/resultValid handshake.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            opImm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] immediateI,
    output logic            busy,
    output logic            resultValid,
    output logic [XLEN-1:0] aluOutput
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     out_q, out_d;

    logic [XLEN-1:0]     op2, base_res, sra_res;
    logic [SW-1:0]       shamt;
    logic                is_m, last;
    logic                sgn1, sgn2, a_neg, b_neg, m_neg;
    logic [XLEN-1:0]     mag1, mag2;
    logic [XLEN:0]       sum, shifted;
    logic                ge;
    logic [XLEN-1:0]     diff, rem_nx, quo, rmd;
    logic [2*XLEN-1:0]   mul_nx, div_nx, acc_nx, prod;
    logic [XLEN-1:0]     m_res;

    assign busy        = (state_q == RUN);
    assign resultValid = valid_q;
    assign aluOutput   = out_q;
    assign is_m        = !opImm && (funct7 == 7'b0000001);
    assign last        = (cnt_q == SW'(XLEN - 1));

    always_comb begin
        op2     = opImm ? immediateI : rs2;
        shamt   = op2[SW-1:0];
        sra_res = $signed(rs1) >>> shamt;
        base_res = '0;
        unique case (funct3)
            3'b000: begin
                if (!opImm && funct7[5]) base_res = rs1 - op2;
                else                     base_res = rs1 + op2;
            end
            3'b001: base_res = rs1 << shamt;
            3'b010: base_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op2)};
            3'b011: base_res = {{(XLEN-1){1'b0}}, rs1 < op2};
            3'b100: base_res = rs1 ^ op2;
            3'b101: begin
                if (funct7[5]) base_res = sra_res;
                else           base_res = rs1 >> shamt;
            end
            3'b110: base_res = rs1 | op2;
            3'b111: base_res = rs1 & op2;
        endcase
    end

    // Operand magnitudes feed an unsigned core; the result sign is fixed up at the end.
    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        unique case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'b010:  sgn1 = 1'b1;
            default: ;
        endcase
        a_neg = sgn1 & rs1[XLEN-1];
        b_neg = sgn2 & rs2[XLEN-1];
        mag1  = a_neg ? -rs1 : rs1;
        mag2  = b_neg ? -rs2 : rs2;
        // A zero divisor keeps the all-ones quotient unsigned.
        if (funct3[2]) m_neg = funct3[1] ? a_neg : ((a_neg ^ b_neg) & (|rs2));
        else           m_neg = a_neg ^ b_neg;
    end

    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nx  = {sum, acc_q[XLEN-1:1]};
        shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = shifted >= {1'b0, opb_q};
        diff    = shifted[XLEN-1:0] - opb_q;
        rem_nx  = ge ? diff : shifted[XLEN-1:0];
        div_nx  = {rem_nx, acc_q[XLEN-2:0], ge};
        acc_nx  = op_q[2] ? div_nx : mul_nx;
        prod    = neg_q ? -acc_nx : acc_nx;
        quo     = acc_nx[XLEN-1:0];
        rmd     = acc_nx[2*XLEN-1:XLEN];
        m_res   = '0;
        unique case (op_q)
            3'b000:                 m_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = neg_q ? -quo : quo;
            3'b110, 3'b111:         m_res = neg_q ? -rmd : rmd;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && is_m) state_d = RUN;
            RUN:  if (last)          state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        valid_d = 1'b0;
        out_d   = out_q;
        if (state_q == IDLE) begin
            if (start && is_m) begin
                cnt_d = '0;
                op_d  = funct3;
                neg_d = m_neg;
                if (funct3[2]) begin
                    opb_d = mag2;
                    acc_d = {{XLEN{1'b0}}, mag1};
                end else begin
                    opb_d = mag1;
                    acc_d = {{XLEN{1'b0}}, mag2};
                end
            end else if (start) begin
                out_d   = base_res;
                valid_d = 1'b1;
            end
        end else begin
            acc_d = acc_nx;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                cnt_d   = '0;
                out_d   = m_res;
                valid_d = 1'b1;
            end
        end
    end

endmodule
